load_store_unit: RTL

Multi-cycle load/store unit downstream of the datapath ALU in the RISC-V core: takes the ALU result as the effective address, runs one request/acknowledge transaction on the data-memory bus, and returns the aligned, sign/zero-extended load value. While the transaction is outstanding it holds the core with `Stall`. It handles byte, halfword and word accesses, rejects misaligned or illegal ones without a bus access, and aborts on a bus timeout.

---
 rtl/load_store_unit.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Multi-cycle load/store unit sitting after the ALU. The ALU result is the
// effective byte address. One request/acknowledge transaction is run on the
// data-memory bus per access, and the aligned, sign/zero-extended load value is
// returned in o_read_data. The core is held with o_stall while the transaction
// is outstanding. Misaligned or illegal accesses are rejected without touching
// the bus, and a transaction with no acknowledge within TIMEOUT cycles aborts.
//
// Parameters
//   TIMEOUT        BUS cycles without i_bus_ack before abort (1..255).
//
// Ports
//   i_clk          clock, all state updates on the rising edge
//   i_reset        synchronous active-high reset
//   i_mem_read     current instruction is a load (held while stalled)
//   i_mem_write    current instruction is a store (wins over i_mem_read)
//   i_funct3       access type (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   i_alu_result   effective byte address
//   i_write_data   store data (rs2)
//   o_read_data    registered, extended load result
//   o_stall        core must hold PC and instruction
//   o_access_err   one-cycle pulse: misaligned, illegal funct3 or timeout
//   o_bus_req      bus request
//   o_bus_we       write qualifier
//   o_bus_addr     word-aligned bus address
//   o_bus_wdata    lane-replicated store data
//   o_bus_byte_en  byte lane enables
//   i_bus_rdata    bus read data, sampled with i_bus_ack
//   i_bus_ack      transfer complete
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_stall,
    output logic        o_access_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_byte_en,
    input  logic [31:0] i_bus_rdata,
    input  logic        i_bus_ack
);

    localparam int unsigned TimeoutClamped = (TIMEOUT > 255) ? 255 : TIMEOUT;
    localparam logic [7:0]  TimeoutCnt     = TimeoutClamped[7:0];

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Transaction latches, captured in IDLE when a legal access starts.
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic        r_we;
    logic [7:0]  r_cnt;
    logic [31:0] r_read_data;
    logic        r_timeout_err;

    logic        w_req;
    logic        w_f3_legal;
    logic        w_misaligned;
    logic        w_start;
    logic        w_illegal;
    logic        w_timeout_hit;
    logic [7:0]  w_cnt_inc;
    logic [7:0]  w_lane_byte;
    logic [15:0] w_lane_half;
    logic [31:0] w_load_value;
    logic [3:0]  w_byte_en;
    logic [31:0] w_store_data;

    // -------------------------------------------------------------------------
    // Access decode (IDLE only; uses live core inputs)
    // -------------------------------------------------------------------------
    assign w_req = i_mem_read | i_mem_write;

    always_comb begin
        w_f3_legal = 1'b0;
        if (i_mem_write) begin
            case (i_funct3)
                3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
                default:                w_f3_legal = 1'b0;
            endcase
        end else begin
            case (i_funct3)
                3'b000, 3'b001, 3'b010,
                3'b100, 3'b101:         w_f3_legal = 1'b1;
                default:                w_f3_legal = 1'b0;
            endcase
        end
    end

    // funct3[1:0] encodes the size for every legal code: 00 byte, 01 half, 10 word.
    assign w_misaligned = ((i_funct3[1:0] == 2'b01) && i_alu_result[0]) ||
                          ((i_funct3[1:0] == 2'b10) && (i_alu_result[1:0] != 2'b00));

    assign w_start   = (r_state == IDLE) && w_req && w_f3_legal && !w_misaligned;
    assign w_illegal = (r_state == IDLE) && w_req && !(w_f3_legal && !w_misaligned);

    assign w_cnt_inc = r_cnt + 8'd1;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state  = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = BUS;
                end
            end
            BUS: begin
                if (i_bus_ack) begin
                    w_next_state = DONE;
                end else if (w_cnt_inc == TimeoutCnt) begin
                    // This is the TIMEOUT-th request cycle with no ack.
                    w_next_state  = DONE;
                    w_timeout_hit = 1'b1;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Load lane selection and extension (from latched address/funct3)
    // -------------------------------------------------------------------------
    always_comb begin
        w_lane_byte = 8'h00;
        case (r_addr[1:0])
            2'b00:   w_lane_byte = i_bus_rdata[7:0];
            2'b01:   w_lane_byte = i_bus_rdata[15:8];
            2'b10:   w_lane_byte = i_bus_rdata[23:16];
            default: w_lane_byte = i_bus_rdata[31:24];
        endcase
    end

    assign w_lane_half = r_addr[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

    always_comb begin
        w_load_value = i_bus_rdata;
        case (r_funct3)
            3'b000:  w_load_value = {{24{w_lane_byte[7]}}, w_lane_byte};
            3'b100:  w_load_value = {24'h000000, w_lane_byte};
            3'b001:  w_load_value = {{16{w_lane_half[15]}}, w_lane_half};
            3'b101:  w_load_value = {16'h0000, w_lane_half};
            default: w_load_value = i_bus_rdata;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_addr        <= 32'h0;
            r_wdata       <= 32'h0;
            r_funct3      <= 3'b000;
            r_we          <= 1'b0;
            r_cnt         <= 8'h00;
            r_read_data   <= 32'h0;
            r_timeout_err <= 1'b0;
        end else begin
            // Only set on the BUS->DONE abort edge, so it lives for DONE only.
            r_timeout_err <= w_timeout_hit;
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_addr   <= i_alu_result;
                        r_wdata  <= i_write_data;
                        r_funct3 <= i_funct3;
                        r_we     <= i_mem_write;
                        r_cnt    <= 8'h00;
                    end else if (w_illegal) begin
                        r_read_data <= 32'h0;
                    end
                end
                BUS: begin
                    if (i_bus_ack) begin
                        if (!r_we) begin
                            r_read_data <= w_load_value;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_timeout_hit) begin
                            r_read_data <= 32'h0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Bus outputs: registered state only
    // -------------------------------------------------------------------------
    always_comb begin
        w_byte_en = 4'b1111;
        case (r_funct3[1:0])
            2'b00:   w_byte_en = 4'b0001 << r_addr[1:0];
            2'b01:   w_byte_en = 4'b0011 << {r_addr[1], 1'b0};
            default: w_byte_en = 4'b1111;
        endcase
    end

    always_comb begin
        w_store_data = 32'h0;
        if (r_we) begin
            case (r_funct3[1:0])
                2'b00:   w_store_data = {4{r_wdata[7:0]}};
                2'b01:   w_store_data = {2{r_wdata[15:0]}};
                default: w_store_data = r_wdata;
            endcase
        end
    end

    // Gating by BUS keeps every bus output at 0 outside a transaction, even
    // though the latches keep the last access.
    always_comb begin
        o_bus_req     = 1'b0;
        o_bus_we      = 1'b0;
        o_bus_addr    = 32'h0;
        o_bus_wdata   = 32'h0;
        o_bus_byte_en = 4'b0000;
        if (r_state == BUS) begin
            o_bus_req     = 1'b1;
            o_bus_we      = r_we;
            o_bus_addr    = {r_addr[31:2], 2'b00};
            o_bus_wdata   = w_store_data;
            o_bus_byte_en = w_byte_en;
        end
    end

    // -------------------------------------------------------------------------
    // Core-facing outputs
    // -------------------------------------------------------------------------
    always_comb begin
        o_stall      = 1'b0;
        o_access_err = 1'b0;
        if (!i_reset) begin
            o_stall      = w_start || (r_state == BUS);
            o_access_err = w_illegal || ((r_state == DONE) && r_timeout_err);
        end
    end

    assign o_read_data = r_read_data;

endmodule
